green_led_effects_driver: RTL and testbench



---
 rtl/green_led_effects_driver.sv | 136 +++++++++++++
 tb/tb_green_led_effects_driver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/green_led_effects_driver.sv
// Green-LED effects driver: sits between the LED pattern PIO and the LED pins,
// adding brightness PWM plus blink and chase (rotate) effects.
module green_led_effects_driver #(
    parameter int unsigned TICK_DIV   = 50000,  // clk cycles per effect tick, >= 2
    parameter int unsigned STEP_TICKS = 250     // ticks per effect step, >= 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pattern_in,
    input  logic [7:0] ctrl_in,
    output logic [7:0] led_out,
    output logic       step_pulse
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned StepW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_TICKS - 1);
    localparam logic [3:0]       PwmLast  = 4'd14;

    localparam logic [1:0] ModeStatic = 2'd0;
    localparam logic [1:0] ModeBlink  = 2'd1;
    localparam logic [1:0] ModeChaseL = 2'd2;
    localparam logic [1:0] ModeChaseR = 2'd3;

    logic [7:0]       shadow_pat_q, shadow_pat_d;
    logic [2:0]       shadow_ctrl_q, shadow_ctrl_d;   // {enable, mode}
    logic [7:0]       work_q, work_d;
    logic             phase_q, phase_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       led_q, led_d;
    logic             step_pulse_q, step_pulse_d;

    logic       reload;
    logic       enable;
    logic [1:0] mode;
    logic       tick;
    logic       step;
    logic       pwm_on;
    logic       unused_ctrl;

    // Bit 7 of the control PIO is reserved.
    assign unused_ctrl = ctrl_in[7];

    // Effect decode and event detection; enable/mode come from the shadow so
    // they stay consistent with the work pattern they were loaded with.
    always_comb begin
        reload = (pattern_in != shadow_pat_q) || (ctrl_in[6:4] != shadow_ctrl_q);
        enable = shadow_ctrl_q[2];
        mode   = shadow_ctrl_q[1:0];
        tick   = enable && (tick_cnt_q == TickLast);
        step   = tick && (step_cnt_q == StepLast);
        // Duty is taken live so brightness changes never restart an effect.
        pwm_on = (pwm_cnt_q < ctrl_in[3:0]);
    end

    // Next-state logic: reload beats any step on the same edge.
    always_comb begin
        shadow_pat_d  = shadow_pat_q;
        shadow_ctrl_d = shadow_ctrl_q;
        work_d        = work_q;
        phase_d       = phase_q;
        tick_cnt_d    = tick_cnt_q;
        step_cnt_d    = step_cnt_q;

        // PWM free-runs independently of reloads; parked at 0 while disabled.
        if (!enable) begin
            pwm_cnt_d = '0;
        end else if (pwm_cnt_q == PwmLast) begin
            pwm_cnt_d = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + 4'd1;
        end

        if (reload) begin
            shadow_pat_d  = pattern_in;
            shadow_ctrl_d = ctrl_in[6:4];
            work_d        = pattern_in;
            phase_d       = 1'b1;
            tick_cnt_d    = '0;
            step_cnt_d    = '0;
        end else if (!enable) begin
            tick_cnt_d = '0;
            step_cnt_d = '0;
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
            end
            if (step) begin
                case (mode)
                    ModeStatic: work_d = work_q;
                    ModeBlink:  phase_d = ~phase_q;
                    ModeChaseL: work_d = {work_q[6:0], work_q[7]};
                    ModeChaseR: work_d = {work_q[0], work_q[7:1]};
                    default:    work_d = work_q;
                endcase
            end
        end

        step_pulse_d = step && !reload;
        led_d        = enable ? (work_q & {8{phase_q & pwm_on}}) : 8'h00;
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_pat_q  <= 8'h00;
            shadow_ctrl_q <= 3'b000;
            work_q        <= 8'h00;
            phase_q       <= 1'b1;
            tick_cnt_q    <= '0;
            step_cnt_q    <= '0;
            pwm_cnt_q     <= 4'd0;
            led_q         <= 8'h00;
            step_pulse_q  <= 1'b0;
        end else begin
            shadow_pat_q  <= shadow_pat_d;
            shadow_ctrl_q <= shadow_ctrl_d;
            work_q        <= work_d;
            phase_q       <= phase_d;
            tick_cnt_q    <= tick_cnt_d;
            step_cnt_q    <= step_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_q         <= led_d;
            step_pulse_q  <= step_pulse_d;
        end
    end

    assign led_out    = led_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_green_led_effects_driver.sv
// Scoreboard bench for green_led_effects_driver with TICK_DIV=4, STEP_TICKS=3
// (one effect step every 12 clocks).
module tb_green_led_effects_driver;

    logic       clk;
    logic       reset_n;
    logic [7:0] pattern_in;
    logic [7:0] ctrl_in;
    logic [7:0] led_out;
    logic       step_pulse;

    typedef struct {
        logic       chk;
        logic [7:0] led;
        logic       pulse;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drv_done = 0;

    logic [7:0] chl [5];
    logic [7:0] chr [4];

    green_led_effects_driver #(
        .TICK_DIV   (4),
        .STEP_TICKS (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pattern_in (pattern_in),
        .ctrl_in    (ctrl_in),
        .led_out    (led_out),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string tag_name(input int id);
        case (id)
            0:       return "reset_hold";
            1:       return "static_a5";
            2:       return "reset_release_reload";
            3:       return "pwm_duty5";
            4:       return "pwm_duty0";
            5:       return "chase_left";
            6:       return "chase_right";
            7:       return "blink_3c";
            8:       return "blink_reload_0f";
            9:       return "disabled";
            10:      return "enable_chase";
            11:      return "reload_step_collision";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic pulse_at(input int j);
        return (j > 0) && (j % 12 == 0);
    endfunction

    // Drive inputs on the falling edge and queue what the outputs must show
    // after the following rising edge.
    task automatic cyc(input logic rst, input logic [7:0] pat, input logic [7:0] ctrl,
                       input logic chk, input logic [7:0] led, input logic pulse, input int id);
        exp_t e;
        @(negedge clk);
        reset_n    = rst;
        pattern_in = pat;
        ctrl_in    = ctrl;
        e.chk   = chk;
        e.led   = led;
        e.pulse = pulse;
        e.id    = id;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 0);
    endtask

    // Monitor: one queued expectation per clock, sampled 2 time units after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (led_out !== e.led || step_pulse !== e.pulse) begin
                        errors++;
                        $display("FAIL %s @%0t: led_out=%02h step_pulse=%b, expected led_out=%02h step_pulse=%b",
                                 tag_name(e.id), $time, led_out, step_pulse, e.led, e.pulse);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] led;
        chl = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18};
        chr = '{8'h81, 8'hC0, 8'h60, 8'h30};
        reset_n    = 1'b0;
        pattern_in = 8'h00;
        ctrl_in    = 8'h00;

        // Static full brightness; reload on the first edge after release.
        do_reset();
        for (int j = 0; j <= 40; j++) begin
            cyc(1'b1, 8'hA5, 8'h4F, 1'b1, (j == 0) ? 8'h00 : 8'hA5, pulse_at(j), 1);
        end

        // Asynchronous reset in the middle of a cycle while lit.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00 || step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: led_out=%02h step_pulse=%b, expected led_out=00 step_pulse=0",
                     led_out, step_pulse);
        end
        cyc(1'b0, 8'hA5, 8'h4F, 1'b1, 8'h00, 1'b0, 0);
        cyc(1'b0, 8'hA5, 8'h4F, 1'b1, 8'h00, 1'b0, 0);
        for (int j = 0; j <= 26; j++) begin
            cyc(1'b1, 8'hA5, 8'h4F, 1'b1, (j == 0) ? 8'h00 : 8'hA5, pulse_at(j), 2);
        end

        // PWM duty 5: lit on 5 of every 15 cycles; then duty 0 without a reload.
        do_reset();
        for (int j = 0; j <= 150; j++) begin
            led = (j > 0 && ((j - 1) % 15) < 5) ? 8'hFF : 8'h00;
            cyc(1'b1, 8'hFF, 8'h45, 1'b1, led, pulse_at(j), 3);
        end
        for (int j = 151; j <= 180; j++) begin
            cyc(1'b1, 8'hFF, 8'h40, 1'b1, 8'h00, pulse_at(j), 4);
        end

        // Chase left from 0x81.
        do_reset();
        for (int j = 0; j <= 48; j++) begin
            led = (j == 0) ? 8'h00 : chl[(j - 1) / 12];
            cyc(1'b1, 8'h81, 8'h6F, 1'b1, led, pulse_at(j), 5);
        end

        // Chase right from 0x81.
        do_reset();
        for (int j = 0; j <= 36; j++) begin
            led = (j == 0) ? 8'h00 : chr[(j - 1) / 12];
            cyc(1'b1, 8'h81, 8'h7F, 1'b1, led, pulse_at(j), 6);
        end

        // Blink, then a new pattern while dark restarts the step timer.
        do_reset();
        for (int j = 0; j <= 17; j++) begin
            led = (j > 0 && ((j - 1) / 12) % 2 == 0) ? 8'h3C : 8'h00;
            cyc(1'b1, 8'h3C, 8'h5F, 1'b1, led, pulse_at(j), 7);
        end
        for (int k = 0; k <= 30; k++) begin
            led = (k > 0 && ((k - 1) / 12) % 2 == 0) ? 8'h0F : 8'h00;
            cyc(1'b1, 8'h0F, 8'h5F, 1'b1, led, pulse_at(k), 8);
        end

        // Disabled: dark and silent; then enable starts a chase.
        do_reset();
        for (int j = 0; j < 100; j++) begin
            cyc(1'b1, 8'h81, 8'h2F, 1'b1, 8'h00, 1'b0, 9);
        end
        for (int j = 0; j <= 23; j++) begin
            led = (j == 0) ? 8'h00 : chl[(j - 1) / 12];
            cyc(1'b1, 8'h81, 8'h6F, 1'b1, led, pulse_at(j), 10);
        end
        // Pattern change lands on the second step edge: no rotation, no pulse.
        cyc(1'b1, 8'h11, 8'h6F, 1'b1, 8'h03, 1'b0, 11);
        for (int k = 1; k <= 16; k++) begin
            led = ((k - 1) / 12 == 0) ? 8'h11 : 8'h22;
            cyc(1'b1, 8'h11, 8'h6F, 1'b1, led, (k == 12), 11);
        end

        drv_done = 1;
        repeat (3) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
